// File: rtl/window_slide_pkg.sv
// Shared types and helpers for the sliding-window result path:
// the writer FSM state encoding and the output-dimension formula.
package window_slide_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic int out_dim(input int img_len, input int kernel, input int stride);
    return (img_len - kernel) / stride + 1;
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs one-bit pixels LSB-first into a DATA_WIDTH word. o_word_next shows the
// word as it will look once the pixel currently on i_pix is loaded.
module bit_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_pix,
  output logic [DATA_WIDTH-1:0] o_word_next,
  output logic                  o_last_bit
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_pack;
  logic [DATA_WIDTH-1:0] w_word;

  always_comb begin
    w_word        = r_pack;
    w_word[r_idx] = i_pix;
  end

  assign o_word_next = w_word;
  assign o_last_bit  = (r_idx == IDX_W'(DATA_WIDTH - 1));

  // The index past the last bit is never used: a full word always goes
  // through WRITE, which clears the packer before the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (i_load) begin
      r_idx  <= r_idx + IDX_W'(1);
      r_pack <= w_word;
    end else begin
      r_idx  <= r_idx;
      r_pack <= r_pack;
    end
  end

endmodule

// File: rtl/window_result_writer.sv
// Collects one binary result pixel per window, packs them into RAM words and
// writes the whole output image starting at base_addr, one word per WRITE cycle.
module window_result_writer
  import window_slide_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_ADDR_WIDTH = 10,
  parameter int IMAGE_ROW_LEN   = 32,
  parameter int IMAGE_COL_LEN   = 32,
  parameter int KERNEL_SIZE     = 3,
  parameter int STRIDE          = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_ADDR_WIDTH-1:0] base_addr,
  input  logic                       pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [DATA_ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0]      ram_w_data,
  output logic                       ram_w_wen,
  output logic                       busy,
  output logic                       done
);

  localparam int OUT_ROWS   = out_dim(IMAGE_ROW_LEN, KERNEL_SIZE, STRIDE);
  localparam int OUT_COLS   = out_dim(IMAGE_COL_LEN, KERNEL_SIZE, STRIDE);
  localparam int OUT_PIXELS = OUT_ROWS * OUT_COLS;
  localparam int OUT_WORDS  = (OUT_PIXELS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int CNT_W      = $clog2(OUT_PIXELS + 1);

  if (KERNEL_SIZE > IMAGE_ROW_LEN || KERNEL_SIZE > IMAGE_COL_LEN ||
      longint'(OUT_WORDS) > (longint'(1) << DATA_ADDR_WIDTH)) begin : g_param_check
    $error("window_result_writer: kernel larger than image or output does not fit address space");
  end

  state_t                     r_state;
  state_t                     w_next_state;
  logic [CNT_W-1:0]           r_pix_cnt;
  logic [DATA_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]      r_data;
  logic                       r_wen;
  logic                       r_done;

  logic                       w_xfer;
  logic                       w_last_pix;
  logic                       w_pass_done;
  logic                       w_pack_clear;
  logic                       w_last_bit;
  logic [DATA_WIDTH-1:0]      w_word_next;

  assign pix_ready    = (r_state == ST_ACCEPT);
  assign busy         = (r_state != ST_IDLE);
  assign w_xfer       = pix_valid && pix_ready;
  assign w_last_pix   = (r_pix_cnt == CNT_W'(OUT_PIXELS - 1));
  assign w_pass_done  = (r_pix_cnt == CNT_W'(OUT_PIXELS));
  assign w_pack_clear = ((r_state == ST_IDLE) && start) || (r_state == ST_WRITE);

  bit_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_pack_clear),
    .i_load      (w_xfer),
    .i_pix       (pix_in),
    .o_word_next (w_word_next),
    .o_last_bit  (w_last_bit)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_ACCEPT;
        else       w_next_state = ST_IDLE;
      end
      ST_ACCEPT: begin
        if (w_xfer && (w_last_bit || w_last_pix)) w_next_state = ST_WRITE;
        else                                      w_next_state = ST_ACCEPT;
      end
      ST_WRITE: begin
        if (w_pass_done) w_next_state = ST_DONE;
        else             w_next_state = ST_ACCEPT;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // wen/done are registered from the next state so they line up exactly with
  // WRITE/DONE; data is captured only on the completing transfer so it stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_wen     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wen  <= (w_next_state == ST_WRITE);
      r_done <= (w_next_state == ST_DONE);
      if ((r_state == ST_IDLE) && start) begin
        r_addr    <= base_addr;
        r_pix_cnt <= '0;
      end else if (r_state == ST_WRITE) begin
        r_addr    <= r_addr + DATA_ADDR_WIDTH'(1);
      end else if (w_xfer) begin
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
      end else begin
        r_addr    <= r_addr;
        r_pix_cnt <= r_pix_cnt;
      end
      if (w_xfer && (w_next_state == ST_WRITE)) r_data <= w_word_next;
      else                                       r_data <= r_data;
    end
  end

  assign ram_w_addr = r_addr;
  assign ram_w_data = r_data;
  assign ram_w_wen  = r_wen;
  assign done       = r_done;

endmodule
